// File: rtl/trng_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : trng_req_arbiter
// Description : Shares one health-tested TRNG byte stream among NREQ consumers
//               through a small byte FIFO and a round-robin one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module trng_req_arbiter #(
  parameter int NREQ         = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int WARMUP_BYTES = 16,
  parameter int REP_LIMIT    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    src_data,
  input  logic                          src_valid,
  input  logic [NREQ-1:0]               req,
  output logic [NREQ-1:0]               gnt,
  output logic [7:0]                    rand_data,
  output logic                          ready,
  output logic                          fault,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(WARMUP_BYTES + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  localparam logic [AW:0]   c_full      = (AW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   c_nreq      = (PW+1)'(NREQ);
  localparam logic [PW-1:0] c_last_req  = PW'(NREQ - 1);
  localparam logic [WW-1:0] c_warm_last = WW'(WARMUP_BYTES - 1);
  localparam logic [RW-1:0] c_rep_limit = RW'(REP_LIMIT);

  typedef enum logic [1:0] {
    S_WARMUP = 2'd0,
    S_RUN    = 2'd1,
    S_FAULT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [WW-1:0]   r_warm_cnt;
  logic [RW-1:0]   r_rep_cnt;
  logic [7:0]      r_last_byte;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic [PW-1:0]   r_rr_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [7:0]      r_rand;

  logic            w_health_act;
  logic            w_rep_match;
  logic [RW-1:0]   w_rep_next;
  logic            w_trip;
  logic            w_push;
  logic            w_pop;
  logic            w_found;
  logic [PW:0]     w_cand;
  logic [PW-1:0]   w_gnt_idx;
  logic [NREQ-1:0] w_gnt_sel;

  // A zero repetition count marks "no byte seen yet", so the first byte always restarts at 1.
  assign w_health_act = src_valid && (r_state != S_FAULT);
  assign w_rep_match  = (r_rep_cnt != '0) && (src_data == r_last_byte);
  assign w_rep_next   = w_rep_match ? (r_rep_cnt + RW'(1)) : RW'(1);
  assign w_trip       = w_health_act && (w_rep_next >= c_rep_limit);

  assign w_pop  = (r_state == S_RUN) && !w_trip && (r_level != '0) && (req != '0);
  assign w_push = (r_state == S_RUN) && src_valid && !w_trip && ((r_level != c_full) || w_pop);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_WARMUP: begin
        if (w_trip)
          w_state_next = S_FAULT;
        else if (src_valid && (r_warm_cnt == c_warm_last))
          w_state_next = S_RUN;
      end
      S_RUN:   if (w_trip) w_state_next = S_FAULT;
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_WARMUP;
    endcase
  end

  // Round-robin search starting at the requester after the last one granted.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_cand >= c_nreq)
        w_cand = w_cand - c_nreq;
      if (!w_found && req[w_cand[PW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_cand[PW-1:0];
      end
    end
    w_gnt_sel = NREQ'(w_found) << w_gnt_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_WARMUP;
      r_warm_cnt  <= '0;
      r_rep_cnt   <= '0;
      r_last_byte <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_rand      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_health_act) begin
        r_rep_cnt   <= w_rep_next;
        r_last_byte <= src_data;
      end
      if ((r_state == S_WARMUP) && src_valid)
        r_warm_cnt <= r_warm_cnt + WW'(1);
      r_gnt  <= w_pop ? w_gnt_sel : '0;
      r_rand <= w_pop ? r_mem[r_rd_ptr] : '0;
      if (w_pop)
        r_rr_ptr <= (w_gnt_idx == c_last_req) ? '0 : (w_gnt_idx + PW'(1));
      if (w_state_next == S_FAULT) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push && !w_pop)
          r_level <= r_level + (AW+1)'(1);
        else if (w_pop && !w_push)
          r_level <= r_level - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= src_data;
  end

  assign gnt        = r_gnt;
  assign rand_data  = r_rand;
  assign ready      = (r_state == S_RUN);
  assign fault      = (r_state == S_FAULT);
  assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_trng_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_trng_req_arbiter
// Description : Scoreboard bench for trng_req_arbiter; expected grants queued at stimulus time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trng_req_arbiter;

  localparam int c_warm = 16;

  logic       clk;
  logic       reset;
  logic [7:0] src_data;
  logic       src_valid;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [7:0] rand_data;
  logic       ready;
  logic       fault;
  logic [2:0] fifo_level;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [11:0] exp_q[$];

  trng_req_arbiter #(
    .NREQ(4), .FIFO_DEPTH(4), .WARMUP_BYTES(c_warm), .REP_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .src_valid(src_valid),
    .req(req), .gnt(gnt), .rand_data(rand_data), .ready(ready),
    .fault(fault), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Grant monitor: every observed grant must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (gnt != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check_value("unexpected_gnt", {28'd0, gnt}, 32'd0);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check_value("gnt", {28'd0, gnt}, {28'd0, e[11:8]});
          check_value("rand_data", {24'd0, rand_data}, {24'd0, e[7:0]});
        end
      end else if (rand_data != 8'h00) begin
        check_value("idle_rand_data", {24'd0, rand_data}, 32'd0);
      end
    end
  end

  task automatic send(input logic [7:0] d);
    src_data  = d;
    src_valid = 1'b1;
    @(posedge clk); #1;
    src_valid = 1'b0;
    src_data  = 8'h00;
  endtask

  task automatic warmup();
    for (int i = 0; i < c_warm; i++) begin
      send(8'(i + 1));
      if (i == c_warm - 2) check_value("warm_not_ready", {31'd0, ready}, 32'd0);
    end
    check_value("warm_ready", {31'd0, ready}, 32'd1);
    check_value("warm_level", {29'd0, fifo_level}, 32'd0);
  endtask

  task automatic expect_gnt(input logic [3:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 32 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check_value(tag, exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #2;
    check_value({tag, "_gnt"},   {28'd0, gnt}, 32'd0);
    check_value({tag, "_data"},  {24'd0, rand_data}, 32'd0);
    check_value({tag, "_ready"}, {31'd0, ready}, 32'd0);
    check_value({tag, "_fault"}, {31'd0, fault}, 32'd0);
    check_value({tag, "_level"}, {29'd0, fifo_level}, 32'd0);
    #4;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; src_data = 8'h00; src_valid = 1'b0; req = 4'b0000;
    #2;
    check_value("rst_gnt",   {28'd0, gnt}, 32'd0);
    check_value("rst_ready", {31'd0, ready}, 32'd0);
    check_value("rst_fault", {31'd0, fault}, 32'd0);
    check_value("rst_level", {29'd0, fifo_level}, 32'd0);
    #20;
    reset = 1'b0;
    @(posedge clk); #1;

    // Warm-up with a pending request, then first delivered byte.
    req = 4'b0001;
    warmup();
    expect_gnt(4'b0001, 8'h11);
    send(8'h11);
    check_value("gnt_early", {28'd0, gnt}, 32'd0);
    @(posedge clk); #1;
    check_value("gnt_latency", {28'd0, gnt}, 32'd1);
    drain("drain_first");

    // Round-robin over four buffered bytes from a fresh pointer.
    req = 4'b0000;
    pulse_reset("rst2");
    warmup();
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
    check_value("rr_level_full", {29'd0, fifo_level}, 32'd4);
    for (int i = 0; i < 4; i++) expect_gnt(4'b0001 << i, 8'hA0 + 8'(i));
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_value("rr_consecutive", {28'd0, gnt}, 32'd1 << i);
    end
    req = 4'b0000;
    drain("drain_rr");
    check_value("rr_level_empty", {29'd0, fifo_level}, 32'd0);

    // Full FIFO: fifth byte dropped, push accepted alongside a pop.
    for (int i = 0; i < 5; i++) send(8'hB0 + 8'(i));
    check_value("full_level", {29'd0, fifo_level}, 32'd4);
    expect_gnt(4'b0010, 8'hB0);
    req = 4'b0010; src_data = 8'hB5; src_valid = 1'b1;
    @(posedge clk); #1;
    src_valid = 1'b0; req = 4'b0000;
    check_value("full_pushpop_level", {29'd0, fifo_level}, 32'd4);
    check_value("full_gnt", {28'd0, gnt}, 32'd2);
    expect_gnt(4'b0001, 8'hB1);
    expect_gnt(4'b0001, 8'hB2);
    expect_gnt(4'b0001, 8'hB3);
    expect_gnt(4'b0001, 8'hB5);
    req = 4'b0001;
    drain("drain_full");
    req = 4'b0000;

    // Repetition count restarts on a differing byte.
    send(8'h33); send(8'h33); send(8'h33); send(8'h44);
    send(8'h33); send(8'h33); send(8'h33);
    check_value("rep_no_fault", {31'd0, fault}, 32'd0);
    check_value("rep_ready", {31'd0, ready}, 32'd1);
    check_value("rep_level", {29'd0, fifo_level}, 32'd4);
    expect_gnt(4'b0001, 8'h33);
    expect_gnt(4'b0001, 8'h33);
    expect_gnt(4'b0001, 8'h33);
    expect_gnt(4'b0001, 8'h44);
    req = 4'b0001;
    drain("drain_rep");
    req = 4'b0000;

    // Health fault on four identical bytes; sticky until reset.
    send(8'hC0); send(8'h5A); send(8'h5A); send(8'h5A);
    check_value("health_pre_fault", {31'd0, fault}, 32'd0);
    send(8'h5A);
    check_value("health_fault", {31'd0, fault}, 32'd1);
    check_value("health_ready", {31'd0, ready}, 32'd0);
    check_value("health_level", {29'd0, fifo_level}, 32'd0);
    req = 4'b1111;
    repeat (5) @(posedge clk);
    #1;
    check_value("health_sticky", {31'd0, fault}, 32'd1);
    check_value("health_no_gnt", {28'd0, gnt}, 32'd0);
    req = 4'b0000;
    pulse_reset("rst_fault");

    // Reset while bytes are buffered and requests pending.
    warmup();
    send(8'hD0); send(8'hD1); send(8'hD2);
    check_value("mid_level", {29'd0, fifo_level}, 32'd3);
    req = 4'b1111;
    pulse_reset("rst_mid");
    warmup();
    expect_gnt(4'b0001, 8'hE0);
    send(8'hE0);
    drain("drain_mid");
    req = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
